// File: rtl/dmem_slave_if.sv
// Request/response bundle between the LSU data port (master) and the data memory (slave).
// Field names keep the data port's established _i/_o naming, seen from the memory side.
interface dmem_slave_if;
  logic        req_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_slave.sv
// Single-outstanding data RAM responder: req/gnt/rvalid handshake, byte-enabled stores,
// programmable wait states and range/byte-enable error reporting.
module dmem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input logic         clk_i,
  input logic         rst_n_i,
  dmem_slave_if.slave bus
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          access;
  logic          accept;

  logic [31:0]   addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  logic          rvalid_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   offset;
  logic          in_range;
  logic          be_ok;
  logic          acc_err;
  logic [AW-1:0] idx;

  logic [31:0]   mem [DEPTH_WORDS];

  assign bus.gnt_o    = bus.req_i & (state_q == S_IDLE);
  assign accept       = bus.gnt_o;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;

  // Modular subtraction makes addresses below BASE_ADDR wrap high and fail the span test.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];
  assign acc_err  = ~in_range | ~be_ok;

  always_comb begin
    case (be_q)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  // NOTE: every output of this block is given a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_WAIT;
        cnt_d   = WAIT_INIT;
      end
      S_WAIT: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        access  = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (accept) begin
        addr_q  <= bus.addr_i;
        we_q    <= bus.we_i;
        be_q    <= bus.be_i;
        wdata_q <= bus.wdata_i;
      end
      rvalid_q <= access;
      err_q    <= access & acc_err;
      rdata_q  <= (access & ~we_q & ~acc_err) ? mem[idx] : 32'd0;
    end
  end

  // NOTE: the storage array has no reset; clearing it would need a reset port on every
  // word, and its contents are meant to survive a reset pulse.
  always_ff @(posedge clk_i) begin
    if (access & we_q & ~acc_err) begin
      for (int n = 0; n < 4; n++) begin
        if (be_q[n]) mem[idx][8*n +: 8] <= wdata_q[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_slave.sv
// Scoreboard bench for dmem_slave: drivers push expected responses at grant time,
// per-instance monitors pop and compare whenever rvalid_o is seen.
module tb_dmem_slave;

  localparam int unsigned WAIT_A = 3;
  localparam int unsigned WAIT_B = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  dmem_slave_if if_a();
  dmem_slave_if if_b();

  dmem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n_a), .bus(if_a.slave));

  dmem_slave #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(WAIT_B)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n_b), .bus(if_b.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if_a.rvalid_o) begin
      if (q_a.size() == 0) check("a_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = q_a.pop_front();
        check("a_rdata", if_a.rdata_o, e.rdata);
        check("a_err", {31'd0, if_a.err_o}, {31'd0, e.err});
        check("a_resp_edge", cyc, e.edge_no);
      end
    end else begin
      check("a_idle_outputs", if_a.rdata_o | {31'd0, if_a.err_o}, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_b.rvalid_o) begin
      if (q_b.size() == 0) check("b_unexpected_rvalid", 32'd1, 32'd0);
      else begin
        e = q_b.pop_front();
        check("b_rdata", if_b.rdata_o, e.rdata);
        check("b_err", {31'd0, if_b.err_o}, {31'd0, e.err});
        check("b_resp_edge", cyc, e.edge_no);
      end
    end else begin
      check("b_idle_outputs", if_b.rdata_o | {31'd0, if_b.err_o}, 32'd0);
    end
  end

  task automatic drive(input bit sel, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (!sel) begin
      if_a.req_i = req; if_a.we_i = we; if_a.be_i = be; if_a.addr_i = addr; if_a.wdata_i = wdata;
    end else begin
      if_b.req_i = req; if_b.we_i = we; if_b.be_i = be; if_b.addr_i = addr; if_b.wdata_i = wdata;
    end
  endtask

  // Presents a request (req stays high afterwards) and returns once it has been accepted.
  task automatic issue(input bit sel, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input bit expect_resp, output int unsigned acc_edge);
    int n;
    exp_t e;
    @(negedge clk);
    drive(sel, 1'b1, we, be, addr, wdata);
    #1;
    n = 0;
    while (!(sel ? if_b.gnt_o : if_a.gnt_o) && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      check("gnt_timeout", 32'd0, 32'd1);
      acc_edge = 0;
      return;
    end
    acc_edge = cyc + 1;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.edge_no = acc_edge + 1 + (sel ? WAIT_B : WAIT_A);
    if (expect_resp) begin
      if (!sel) q_a.push_back(e);
      else      q_b.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit sel);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  initial begin
    int unsigned e1, e2, tmp;
    int n;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("reset_rvalid_a", {31'd0, if_a.rvalid_o}, 32'd0);
    check("reset_rdata_a", if_a.rdata_o, 32'd0);
    check("reset_err_a", {31'd0, if_a.err_o}, 32'd0);
    check("reset_gnt_idle_a", {31'd0, if_a.gnt_o}, 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Store/load round trip, with busy-grant and back-to-back spacing checks.
    issue(1'b0, 1'b1, 4'b1111, 32'h04, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, e1);
    @(negedge clk); #1;
    check("busy_gnt_wait", {31'd0, if_a.gnt_o}, 32'd0);
    issue(1'b0, 1'b0, 4'b1111, 32'h04, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, e2);
    check("accept_spacing", e2 - e1, WAIT_A + 3);

    // Byte store merges into the existing word.
    issue(1'b0, 1'b1, 4'b0010, 32'h05, 32'h0000_AA00, 32'h0, 1'b0, 1'b1, tmp);
    issue(1'b0, 1'b0, 4'b1111, 32'h04, 32'h0, 32'hDEAD_AAEF, 1'b0, 1'b1, tmp);

    // Errors: out-of-range load, misaligned half, empty enables; memory left intact.
    issue(1'b0, 1'b0, 4'b1111, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b1, tmp);
    issue(1'b0, 1'b1, 4'b0110, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, tmp);
    issue(1'b0, 1'b1, 4'b0000, 32'h04, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, tmp);
    issue(1'b0, 1'b0, 4'b0001, 32'h07, 32'h0, 32'hDEAD_AAEF, 1'b0, 1'b1, tmp);
    issue(1'b0, 1'b1, 4'b1100, 32'h06, 32'h5A5A_0000, 32'h0, 1'b0, 1'b1, tmp);
    issue(1'b0, 1'b0, 4'b1111, 32'h04, 32'h0, 32'h5A5A_AAEF, 1'b0, 1'b1, tmp);
    issue(1'b0, 1'b1, 4'b1111, 32'h0FFC, 32'h1122_3344, 32'h0, 1'b0, 1'b1, tmp);
    issue(1'b0, 1'b0, 4'b1111, 32'h0FFC, 32'h0, 32'h1122_3344, 1'b0, 1'b1, tmp);

    // req held high with alternating stores and loads.
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 1'b1, 4'b1111, 32'h10 + 32'(4*i), 32'hA000_0000 | 32'(i * 32'h1111),
            32'h0, 1'b0, 1'b1, tmp);
      issue(1'b0, 1'b0, 4'b1111, 32'h10 + 32'(4*i), 32'h0,
            32'hA000_0000 | 32'(i * 32'h1111), 1'b0, 1'b1, tmp);
    end
    idle(1'b0);

    // Instance B: non-zero base, reset during wait drops the pending store.
    issue(1'b1, 1'b1, 4'b1111, 32'h1008, 32'h1111_1111, 32'h0, 1'b0, 1'b1, tmp);
    issue(1'b1, 1'b0, 4'b1111, 32'h1008, 32'h0, 32'h1111_1111, 1'b0, 1'b1, tmp);
    issue(1'b1, 1'b1, 4'b1111, 32'h1008, 32'h1234_5678, 32'h0, 1'b0, 1'b0, tmp);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    rst_n_b = 1'b0;
    @(negedge clk);
    check("reset_mid_rvalid_b", {31'd0, if_b.rvalid_o}, 32'd0);
    rst_n_b = 1'b1;
    repeat (6) @(negedge clk);
    issue(1'b1, 1'b0, 4'b1111, 32'h1008, 32'h0, 32'h1111_1111, 1'b0, 1'b1, tmp);
    issue(1'b1, 1'b0, 4'b1111, 32'h0FFC, 32'h0, 32'h0, 1'b1, 1'b1, tmp);
    issue(1'b1, 1'b0, 4'b1111, 32'h1040, 32'h0, 32'h0, 1'b1, 1'b1, tmp);
    issue(1'b1, 1'b1, 4'b1111, 32'h103C, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, tmp);
    issue(1'b1, 1'b0, 4'b1000, 32'h103C, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, tmp);
    idle(1'b1);

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("a_pending_responses", q_a.size(), 32'd0);
    check("b_pending_responses", q_b.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
